// File: rtl/vga_scanout_if.sv
// Framebuffer read port and VGA pin bundle between the scanout engine and its surroundings.
interface vga_scanout_if;
  logic        fb_rd_en;
  logic [18:0] fb_addr;
  logic [11:0] fb_din;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output fb_rd_en, fb_addr, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
    input  fb_din
  );

  modport slave (
    input  fb_rd_en, fb_addr, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
    output fb_din
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer scanout: one read per visible pixel, with sync
// realigned to the returned pixel data through a RD_LATENCY-deep delay line.
module vga_scanout #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.master bus
);
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned A_W      = 19;
  localparam int unsigned PIX_W    = 12;
  localparam int unsigned ADDR_MAX = H_VISIBLE * V_VISIBLE - 1;
  localparam int unsigned HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic [H_W-1:0]        h_cnt_q, h_cnt_d;
  logic [V_W-1:0]        v_cnt_q, v_cnt_d;
  logic [A_W-1:0]        lin_addr_q, lin_addr_d;
  logic                  visible_c, hsync_raw_c, vsync_raw_c, first_c;
  logic [A_W-1:0]        fb_addr_q, fb_addr_d;
  logic                  fb_rd_en_q, fb_rd_en_d;
  logic                  hs1_q, hs1_d, vs1_q, vs1_d, first1_q, first1_d;
  logic [RD_LATENCY-1:0] vis_dly_q, vis_dly_d;
  logic [RD_LATENCY-1:0] hs_dly_q, hs_dly_d;
  logic [RD_LATENCY-1:0] vs_dly_q, vs_dly_d;
  logic [RD_LATENCY-1:0] first_dly_q, first_dly_d;
  logic [PIX_W-1:0]      rgb_q, rgb_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;
  logic                  frame_start_q, frame_start_d;

  // Raster position decode
  always_comb begin
    visible_c   = (h_cnt_q < H_W'(H_VISIBLE)) && (v_cnt_q < V_W'(V_VISIBLE));
    hsync_raw_c = !((h_cnt_q >= H_W'(HS_FIRST)) && (h_cnt_q <= H_W'(HS_LAST)));
    vsync_raw_c = !((v_cnt_q >= V_W'(VS_FIRST)) && (v_cnt_q <= V_W'(VS_LAST)));
    first_c     = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Raster counters and linear address; the address parks at 0 after the last pixel
  always_comb begin
    h_cnt_d    = h_cnt_q + H_W'(1);
    v_cnt_d    = v_cnt_q;
    lin_addr_d = lin_addr_q;
    if (h_cnt_q == H_W'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + V_W'(1);
    end
    if ((h_cnt_d == '0) && (v_cnt_d == '0)) begin
      lin_addr_d = '0;
    end else if (visible_c) begin
      lin_addr_d = (lin_addr_q == A_W'(ADDR_MAX)) ? '0 : lin_addr_q + A_W'(1);
    end
  end

  // Read issue stage and delay line matching the framebuffer read latency
  always_comb begin
    fb_addr_d   = visible_c ? lin_addr_q : '0;
    fb_rd_en_d  = visible_c;
    hs1_d       = hsync_raw_c;
    vs1_d       = vsync_raw_c;
    first1_d    = first_c;
    vis_dly_d   = vis_dly_q;
    hs_dly_d    = hs_dly_q;
    vs_dly_d    = vs_dly_q;
    first_dly_d = first_dly_q;
    vis_dly_d[0]   = fb_rd_en_q;
    hs_dly_d[0]    = hs1_q;
    vs_dly_d[0]    = vs1_q;
    first_dly_d[0] = first1_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vis_dly_d[i]   = vis_dly_q[i-1];
      hs_dly_d[i]    = hs_dly_q[i-1];
      vs_dly_d[i]    = vs_dly_q[i-1];
      first_dly_d[i] = first_dly_q[i-1];
    end
  end

  // Pin stage: blank pixels forced black
  always_comb begin
    rgb_d         = vis_dly_q[RD_LATENCY-1] ? bus.fb_din : '0;
    hsync_d       = hs_dly_q[RD_LATENCY-1];
    vsync_d       = vs_dly_q[RD_LATENCY-1];
    frame_start_d = first_dly_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      lin_addr_q    <= '0;
      fb_addr_q     <= '0;
      fb_rd_en_q    <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      first1_q      <= 1'b0;
      vis_dly_q     <= '0;
      hs_dly_q      <= '1;
      vs_dly_q      <= '1;
      first_dly_q   <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      lin_addr_q    <= lin_addr_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      first1_q      <= first1_d;
      vis_dly_q     <= vis_dly_d;
      hs_dly_q      <= hs_dly_d;
      vs_dly_q      <= vs_dly_d;
      first_dly_q   <= first_dly_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_rd_en    = fb_rd_en_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = frame_start_q;
endmodule
